// File: rtl/bp_pkg.sv
// Shared types and defaults for the branch-predictor update scheduler.
package bp_pkg;

    localparam int BP_PC_W      = 32;
    localparam int BP_DEPTH_DEF = 4;
    localparam int BP_CNT_W_DEF = 32;

    typedef struct packed {
        logic [BP_PC_W-1:0] pc;
        logic               taken;
    } bp_upd_t;

endpackage

// File: rtl/bp_upd_fifo.sv
// Circular queue of pending predictor updates, up to two pushes and one pop per cycle.
// Latency: a pushed entry is visible at head_dat the cycle after the push.
// Backpressure: none internally; the caller limits push_n to the free space.
module bp_upd_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = BP_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [1:0]               push_n,
    input  bp_upd_t                  push_dat0,
    input  bp_upd_t                  push_dat1,
    input  logic                     pop,
    output bp_upd_t                  head_dat,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   cnt_t;

    bp_upd_t mem [DEPTH];
    ptr_t    wr_ptr;
    ptr_t    rd_ptr;
    ptr_t    wr_ptr_p1;

    assign wr_ptr_p1 = wr_ptr + ptr_t'(1);
    assign head_dat  = mem[rd_ptr];

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push_n != 2'd0) mem[wr_ptr]    <= push_dat0;
        if (push_n == 2'd2) mem[wr_ptr_p1] <= push_dat1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + ptr_t'(push_n);
            rd_ptr <= rd_ptr + ptr_t'(pop);
            count  <= count + cnt_t'(push_n) - cnt_t'(pop);
        end
    end

endmodule

// File: rtl/bp_update_ctrl.sv
// Merges ID/EX branch resolutions in program order onto the single predictor update port.
// Latency: 1 cycle from arrival to bp_update with an empty queue; queued entries drain one per cycle.
// Backpressure: res_stall when occupancy >= DEPTH-1; excess arrivals are dropped (youngest first) and flagged.
module bp_update_ctrl
    import bp_pkg::*;
#(
    parameter int DEPTH = BP_DEPTH_DEF,
    parameter int CNT_W = BP_CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ex_res_valid,
    input  logic [31:0]        ex_res_pc,
    input  logic               ex_res_taken,
    input  logic               ex_res_pred,
    input  logic               id_res_valid,
    input  logic [31:0]        id_res_pc,
    input  logic               id_res_taken,
    input  logic               id_res_pred,
    output logic               bp_update,
    output logic [31:0]        bp_pc_update,
    output logic               bp_branch_actual,
    output logic               res_stall,
    output logic               mispredict,
    output logic [CNT_W-1:0]   cnt_branch,
    output logic [CNT_W-1:0]   cnt_mispredict,
    output logic               overflow_err
);

    localparam int QC_W = $clog2(DEPTH) + 1;

    bp_upd_t           ex_upd, id_upd, head_upd, issue_upd, push0, push1;
    logic              issue_vld, pop, drop;
    logic [1:0]        req_n, push_n, inc_br, inc_mp;
    logic [QC_W-1:0]   count_q;
    logic [QC_W:0]     free;
    logic              ex_mp, id_mp;

    assign ex_upd = '{pc: ex_res_pc, taken: ex_res_taken};
    assign id_upd = '{pc: id_res_pc, taken: id_res_taken};

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [1:0] inc);
        logic [CNT_W:0] s;
        s = {1'b0, c} + (CNT_W+1)'(inc);
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    // Oldest candidate issues; the rest are queued in order (head < EX < ID).
    always_comb begin
        issue_vld = 1'b0;
        issue_upd = ex_upd;
        pop       = 1'b0;
        push0     = ex_upd;
        push1     = id_upd;
        req_n     = 2'd0;
        push_n    = 2'd0;
        drop      = 1'b0;
        if (count_q != '0) begin
            issue_vld = 1'b1;
            issue_upd = head_upd;
            pop       = 1'b1;
            if (ex_res_valid) begin
                req_n = id_res_valid ? 2'd2 : 2'd1;
            end else if (id_res_valid) begin
                push0 = id_upd;
                req_n = 2'd1;
            end
        end else if (ex_res_valid) begin
            issue_vld = 1'b1;
            if (id_res_valid) begin
                push0 = id_upd;
                req_n = 2'd1;
            end
        end else if (id_res_valid) begin
            issue_vld = 1'b1;
            issue_upd = id_upd;
        end
        free = (QC_W+1)'(DEPTH) - {1'b0, count_q} + (QC_W+1)'(pop);
        if ((QC_W+1)'(req_n) > free) begin
            push_n = free[1:0];
            drop   = 1'b1;
        end else begin
            push_n = req_n;
        end
    end

    bp_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push_n    (push_n),
        .push_dat0 (push0),
        .push_dat1 (push1),
        .pop       (pop),
        .head_dat  (head_upd),
        .count     (count_q)
    );

    assign res_stall = (count_q >= QC_W'(DEPTH - 1));
    assign ex_mp     = ex_res_valid && (ex_res_taken != ex_res_pred);
    assign id_mp     = id_res_valid && (id_res_taken != id_res_pred);
    assign inc_br    = {1'b0, ex_res_valid} + {1'b0, id_res_valid};
    assign inc_mp    = {1'b0, ex_mp} + {1'b0, id_mp};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bp_update        <= 1'b0;
            bp_pc_update     <= '0;
            bp_branch_actual <= 1'b0;
            mispredict       <= 1'b0;
            cnt_branch       <= '0;
            cnt_mispredict   <= '0;
            overflow_err     <= 1'b0;
        end else begin
            bp_update <= issue_vld;
            if (issue_vld) begin
                bp_pc_update     <= issue_upd.pc;
                bp_branch_actual <= issue_upd.taken;
            end
            mispredict     <= ex_mp | id_mp;
            cnt_branch     <= sat_add(cnt_branch, inc_br);
            cnt_mispredict <= sat_add(cnt_mispredict, inc_mp);
            if (drop) overflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Directed and randomized checks of bp_update_ctrl against a list-based reference model.
module tb_bp_update_ctrl;
    import bp_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              ex_res_valid = 1'b0, ex_res_taken = 1'b0, ex_res_pred = 1'b0;
    logic              id_res_valid = 1'b0, id_res_taken = 1'b0, id_res_pred = 1'b0;
    logic [31:0]       ex_res_pc = '0, id_res_pc = '0;
    logic              bp_update, bp_branch_actual, res_stall, mispredict, overflow_err;
    logic [31:0]       bp_pc_update;
    logic [CNT_W-1:0]  cnt_branch, cnt_mispredict;

    int checks = 0;
    int fails  = 0;

    // Reference model state
    bp_upd_t     mq[$];
    logic        e_upd, e_act, e_mis, e_ovf;
    logic [31:0] e_pc;
    int          e_cb, e_cm;
    int          n_issued;
    int          n_arrived;
    logic        saw_stall;

    bp_update_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .ex_res_valid     (ex_res_valid),
        .ex_res_pc        (ex_res_pc),
        .ex_res_taken     (ex_res_taken),
        .ex_res_pred      (ex_res_pred),
        .id_res_valid     (id_res_valid),
        .id_res_pc        (id_res_pc),
        .id_res_taken     (id_res_taken),
        .id_res_pred      (id_res_pred),
        .bp_update        (bp_update),
        .bp_pc_update     (bp_pc_update),
        .bp_branch_actual (bp_branch_actual),
        .res_stall        (res_stall),
        .mispredict       (mispredict),
        .cnt_branch       (cnt_branch),
        .cnt_mispredict   (cnt_mispredict),
        .overflow_err     (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".upd"},   32'(bp_update), 32'(e_upd));
        chk({tag, ".pc"},    bp_pc_update, e_pc);
        chk({tag, ".act"},   32'(bp_branch_actual), 32'(e_act));
        chk({tag, ".mis"},   32'(mispredict), 32'(e_mis));
        chk({tag, ".cb"},    32'(cnt_branch), 32'(e_cb));
        chk({tag, ".cm"},    32'(cnt_mispredict), 32'(e_cm));
        chk({tag, ".ovf"},   32'(overflow_err), 32'(e_ovf));
        chk({tag, ".stall"}, 32'(res_stall), 32'(mq.size() >= DEPTH - 1));
    endtask

    task automatic model_reset();
        mq.delete();
        e_upd = 1'b0; e_pc = '0; e_act = 1'b0; e_mis = 1'b0; e_ovf = 1'b0;
        e_cb = 0; e_cm = 0;
    endtask

    // One clock: drive arrivals, advance the model, then compare after the edge.
    task automatic step(input string tag,
                        input logic ev, input logic [31:0] ep, input logic et, input logic epr,
                        input logic iv, input logic [31:0] ip, input logic it, input logic ipr);
        bp_upd_t c[$];
        bp_upd_t u;
        int nm;
        ex_res_valid = ev; ex_res_pc = ep; ex_res_taken = et; ex_res_pred = epr;
        id_res_valid = iv; id_res_pc = ip; id_res_taken = it; id_res_pred = ipr;
        @(posedge clk);
        c = mq;
        if (ev) begin u.pc = ep; u.taken = et; c.push_back(u); end
        if (iv) begin u.pc = ip; u.taken = it; c.push_back(u); end
        nm = int'(ev && (et != epr)) + int'(iv && (it != ipr));
        n_arrived += int'(ev) + int'(iv);
        if (c.size() > 0) begin
            e_upd = 1'b1; e_pc = c[0].pc; e_act = c[0].taken;
            void'(c.pop_front());
        end else begin
            e_upd = 1'b0;
        end
        while (c.size() > DEPTH) begin
            void'(c.pop_back());
            e_ovf = 1'b1;
        end
        mq    = c;
        e_mis = (nm > 0);
        e_cb  = (e_cb + int'(ev) + int'(iv) > CMAX) ? CMAX : e_cb + int'(ev) + int'(iv);
        e_cm  = (e_cm + nm > CMAX) ? CMAX : e_cm + nm;
        #1;
        if (bp_update) n_issued++;
        if (res_stall) saw_stall = 1'b1;
        check_all(tag);
        ex_res_valid = 1'b0;
        id_res_valid = 1'b0;
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        ex_res_valid = 1'b0;
        id_res_valid = 1'b0;
        reset_n = 1'b0;
        #2;
        model_reset();
        check_all("reset");
        @(negedge clk);
        reset_n = 1'b1;
        n_issued = 0;
        n_arrived = 0;
        saw_stall = 1'b0;
    endtask

    initial begin
        logic        ev, iv, et, it, epr, ipr;
        logic [31:0] base;
        int          guard;

        model_reset();
        n_issued = 0; n_arrived = 0; saw_stall = 1'b0;
        #12;
        check_all("por");
        @(negedge clk);
        reset_n = 1'b1;

        // Single EX arrival
        step("single_ex", 1'b1, 32'h0040_0010, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("single_ex.upd_c", 32'(bp_update), 32'd1);
        chk("single_ex.pc_c", bp_pc_update, 32'h0040_0010);
        chk("single_ex.mis_c", 32'(mispredict), 32'd1);
        chk("single_ex.cm_c", 32'(cnt_mispredict), 32'd1);
        idle("single_ex.hold");
        chk("single_ex.hold_pc", bp_pc_update, 32'h0040_0010);

        // Simultaneous EX and ID
        do_reset();
        step("simul", 1'b1, 32'h100, 1'b0, 1'b0, 1'b1, 32'h104, 1'b1, 1'b1);
        chk("simul.pc0", bp_pc_update, 32'h100);
        chk("simul.cb", 32'(cnt_branch), 32'd2);
        idle("simul.n2");
        chk("simul.pc1", bp_pc_update, 32'h104);
        chk("simul.upd1", 32'(bp_update), 32'd1);
        idle("simul.n3");

        // Burst honouring the stall
        do_reset();
        base = 32'h0000_2000;
        for (int k = 0; k < 10; k++) begin
            if (mq.size() >= DEPTH - 1)
                step("burst_stalled", 1'b1, base, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
            else
                step("burst", 1'b1, base, 1'b0, 1'b0, 1'b1, base + 32'h4, 1'b1, 1'b1);
            base = base + 32'h8;
        end
        guard = 0;
        while (mq.size() > 0 && guard < 20) begin idle("burst.drain"); guard++; end
        idle("burst.tail");
        chk("burst.ovf", 32'(overflow_err), 32'd0);
        chk("burst.saw_stall", 32'(saw_stall), 32'd1);
        chk("burst.all_issued", 32'(n_issued), 32'(n_arrived));

        // Ignored stall
        do_reset();
        for (int k = 0; k < 6; k++)
            step("nostall", 1'b1, 32'h3000 + 32'(k * 8), 1'b0, 1'b0, 1'b1, 32'h3004 + 32'(k * 8), 1'b1, 1'b1);
        chk("nostall.ovf", 32'(overflow_err), 32'd1);
        chk("nostall.cb", 32'(cnt_branch), 32'd12);
        for (int k = 0; k < 6; k++) idle("nostall.drain");
        chk("nostall.ovf_sticky", 32'(overflow_err), 32'd1);

        // Reset mid-drain
        do_reset();
        for (int k = 0; k < 3; k++)
            step("rstdrain.fill", 1'b1, 32'h4000 + 32'(k * 8), 1'b1, 1'b0, 1'b1, 32'h4004 + 32'(k * 8), 1'b0, 1'b0);
        chk("rstdrain.stall_before", 32'(res_stall), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rstdrain.upd0", 32'(bp_update), 32'd0);
        chk("rstdrain.pc0", bp_pc_update, 32'd0);
        chk("rstdrain.stall0", 32'(res_stall), 32'd0);
        chk("rstdrain.cb0", 32'(cnt_branch), 32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        n_issued = 0;
        for (int k = 0; k < 5; k++) idle("rstdrain.after");
        chk("rstdrain.no_issue", 32'(n_issued), 32'd0);

        // Counter saturation
        do_reset();
        for (int k = 0; k < 7; k++)
            step("sat.fill", 1'b1, 32'h5000, 1'b1, 1'b0, 1'b1, 32'h5004, 1'b0, 1'b1);
        chk("sat.cm14", 32'(cnt_mispredict), 32'd14);
        step("sat.two", 1'b1, 32'h5008, 1'b1, 1'b0, 1'b1, 32'h500c, 1'b0, 1'b1);
        chk("sat.cm15", 32'(cnt_mispredict), 32'd15);
        chk("sat.cb15", 32'(cnt_branch), 32'd15);
        step("sat.one", 1'b1, 32'h5010, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("sat.cm_hold", 32'(cnt_mispredict), 32'd15);

        // Randomized traffic, mostly honouring the stall
        do_reset();
        for (int k = 0; k < 300; k++) begin
            ev  = 1'($urandom_range(0, 1));
            iv  = 1'($urandom_range(0, 1));
            et  = 1'($urandom_range(0, 1));
            it  = 1'($urandom_range(0, 1));
            epr = 1'($urandom_range(0, 1));
            ipr = 1'($urandom_range(0, 1));
            if (mq.size() >= DEPTH - 1 && $urandom_range(0, 7) != 0) iv = 1'b0;
            if (k == 150) begin
                do_reset();
            end
            step("rand", ev, $urandom & 32'hFFFF_FFFC, et, epr, iv, $urandom & 32'hFFFF_FFFC, it, ipr);
        end
        guard = 0;
        while (mq.size() > 0 && guard < 20) begin idle("rand.drain"); guard++; end
        idle("rand.tail");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
